// File: rtl/ma_cvxif_pkg.sv
// Shared types and constants for the CV-X-IF matrix-accelerator adapter.
// Queue entries are sized for the widest supported operands (XLEN <= 64, ID_WIDTH <= 16).
package ma_cvxif_pkg;

    localparam logic [6:0]  OPC_CUSTOM0    = 7'h0B;
    localparam int unsigned WB_BIT         = 12;
    localparam int unsigned ENTRY_XLEN_MAX = 64;
    localparam int unsigned ENTRY_ID_MAX   = 16;

    typedef struct packed {
        logic [31:0]               instr;
        logic [ENTRY_XLEN_MAX-1:0] rs1;
        logic [ENTRY_XLEN_MAX-1:0] rs2;
        logic [ENTRY_ID_MAX-1:0]   id;
        logic                      we;
    } cvxif_entry_t;

    function automatic logic is_custom0(input logic [31:0] instr);
        return instr[6:0] == OPC_CUSTOM0;
    endfunction

endpackage

// File: rtl/ma_cvxif_fifo.sv
// Power-of-two command queue with push/pop/flush and full/empty flags.
// The head is read combinationally so a pushed entry is visible the following cycle.
module ma_cvxif_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Flush has priority over any concurrent push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/ma_cvxif_adapter.sv
// CV-X-IF adapter: decodes custom-0 issues into a command queue and returns completions.
// Define MA_CVXIF_STATS_EN to enable saturating accept/reject issue counters.
module ma_cvxif_adapter
    import ma_cvxif_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [31:0]         issue_instr_i,
    input  logic [XLEN-1:0]     issue_rs1_i,
    input  logic [XLEN-1:0]     issue_rs2_i,
    input  logic [ID_WIDTH-1:0] issue_id_i,
    output logic                issue_accept_o,
    output logic                issue_writeback_o,
    output logic                cmd_valid_o,
    input  logic                cmd_ready_i,
    output logic [31:0]         cmd_instr_o,
    output logic [XLEN-1:0]     cmd_rs1_o,
    output logic [XLEN-1:0]     cmd_rs2_o,
    output logic [ID_WIDTH-1:0] cmd_id_o,
    output logic                cmd_we_o,
    input  logic                done_valid_i,
    output logic                done_ready_o,
    input  logic [ID_WIDTH-1:0] done_id_i,
    input  logic [XLEN-1:0]     done_data_i,
    input  logic                done_we_i,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [ID_WIDTH-1:0] result_id_o,
    output logic [XLEN-1:0]     result_data_o,
    output logic                result_we_o,
    input  logic                flush_i,
    output logic [15:0]         stat_accept_o,
    output logic [15:0]         stat_reject_o
);

    localparam int unsigned ENTRY_W = $bits(cvxif_entry_t);

    cvxif_entry_t       tail_entry, head_entry;
    logic [ENTRY_W-1:0] head_bits;
    logic               accept, issue_hs, push, pop, full, empty;
    logic               unused_head;

    always_comb begin
        accept                        = is_custom0(issue_instr_i);
        tail_entry                    = '0;
        tail_entry.instr              = issue_instr_i;
        tail_entry.rs1[XLEN-1:0]      = issue_rs1_i;
        tail_entry.rs2[XLEN-1:0]      = issue_rs2_i;
        tail_entry.id[ID_WIDTH-1:0]   = issue_id_i;
        tail_entry.we                 = accept & issue_instr_i[WB_BIT];
    end

    assign issue_accept_o    = accept;
    assign issue_writeback_o = tail_entry.we;
    assign issue_ready_o     = !full && !flush_i;
    assign issue_hs          = issue_valid_i && issue_ready_o;
    assign push              = issue_hs && accept;
    assign pop               = cmd_valid_o && cmd_ready_i;

    ma_cvxif_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .push_i      (push),
        .push_data_i (tail_entry),
        .pop_i       (pop),
        .pop_data_o  (head_bits),
        .full_o      (full),
        .empty_o     (empty)
    );

    assign head_entry  = cvxif_entry_t'(head_bits);
    assign cmd_valid_o = !empty;
    assign cmd_instr_o = head_entry.instr;
    assign cmd_rs1_o   = head_entry.rs1[XLEN-1:0];
    assign cmd_rs2_o   = head_entry.rs2[XLEN-1:0];
    assign cmd_id_o    = head_entry.id[ID_WIDTH-1:0];
    assign cmd_we_o    = head_entry.we;
    // Padding bits above XLEN/ID_WIDTH are always zero.
    assign unused_head = ^{head_entry.rs1, head_entry.rs2, head_entry.id};

    // One-entry result register; flush deliberately has no effect here.
    logic                result_valid_q, result_valid_d;
    logic [ID_WIDTH-1:0] result_id_q, result_id_d;
    logic [XLEN-1:0]     result_data_q, result_data_d;
    logic                result_we_q, result_we_d;

    assign done_ready_o = !result_valid_q || result_ready_i;

    always_comb begin
        result_valid_d = result_valid_q;
        result_id_d    = result_id_q;
        result_data_d  = result_data_q;
        result_we_d    = result_we_q;
        if (done_valid_i && done_ready_o) begin
            result_valid_d = 1'b1;
            result_id_d    = done_id_i;
            result_data_d  = done_data_i;
            result_we_d    = done_we_i;
        end else if (result_ready_i) begin
            result_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_valid_q <= 1'b0;
            result_id_q    <= '0;
            result_data_q  <= '0;
            result_we_q    <= 1'b0;
        end else begin
            result_valid_q <= result_valid_d;
            result_id_q    <= result_id_d;
            result_data_q  <= result_data_d;
            result_we_q    <= result_we_d;
        end
    end

    assign result_valid_o = result_valid_q;
    assign result_id_o    = result_id_q;
    assign result_data_o  = result_data_q;
    assign result_we_o    = result_we_q;

`ifdef MA_CVXIF_STATS_EN
    logic [15:0] stat_accept_q, stat_accept_d;
    logic [15:0] stat_reject_q, stat_reject_d;

    always_comb begin
        stat_accept_d = stat_accept_q;
        stat_reject_d = stat_reject_q;
        if (issue_hs) begin
            if (accept) begin
                if (stat_accept_q != 16'hFFFF) stat_accept_d = stat_accept_q + 16'd1;
            end else begin
                if (stat_reject_q != 16'hFFFF) stat_reject_d = stat_reject_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_accept_q <= '0;
            stat_reject_q <= '0;
        end else begin
            stat_accept_q <= stat_accept_d;
            stat_reject_q <= stat_reject_d;
        end
    end

    assign stat_accept_o = stat_accept_q;
    assign stat_reject_o = stat_reject_q;
`else
    assign stat_accept_o = 16'h0000;
    assign stat_reject_o = 16'h0000;
`endif

endmodule

// File: tb/tb_ma_cvxif_adapter.sv
// Self-checking bench for ma_cvxif_adapter: directed scenarios plus a randomized run
// against a transaction-level queue/register model.
module tb_ma_cvxif_adapter;

    localparam int XLEN  = 32;
    localparam int IDW   = 4;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            issue_valid, issue_ready, issue_accept, issue_wb;
    logic [31:0]     issue_instr;
    logic [XLEN-1:0] issue_rs1, issue_rs2;
    logic [IDW-1:0]  issue_id;
    logic            cmd_valid, cmd_ready, cmd_we;
    logic [31:0]     cmd_instr;
    logic [XLEN-1:0] cmd_rs1, cmd_rs2;
    logic [IDW-1:0]  cmd_id;
    logic            done_valid, done_ready, done_we;
    logic [IDW-1:0]  done_id;
    logic [XLEN-1:0] done_data;
    logic            result_valid, result_ready, result_we;
    logic [IDW-1:0]  result_id;
    logic [XLEN-1:0] result_data;
    logic            flush;
    logic [15:0]     stat_acc, stat_rej;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0]     instr;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [IDW-1:0]  id;
        logic            we;
    } ent_t;

    always #5 clk = ~clk;

    ma_cvxif_adapter #(.XLEN(XLEN), .ID_WIDTH(IDW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .issue_valid_i(issue_valid), .issue_ready_o(issue_ready), .issue_instr_i(issue_instr),
        .issue_rs1_i(issue_rs1), .issue_rs2_i(issue_rs2), .issue_id_i(issue_id),
        .issue_accept_o(issue_accept), .issue_writeback_o(issue_wb),
        .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_instr_o(cmd_instr),
        .cmd_rs1_o(cmd_rs1), .cmd_rs2_o(cmd_rs2), .cmd_id_o(cmd_id), .cmd_we_o(cmd_we),
        .done_valid_i(done_valid), .done_ready_o(done_ready), .done_id_i(done_id),
        .done_data_i(done_data), .done_we_i(done_we),
        .result_valid_o(result_valid), .result_ready_i(result_ready), .result_id_o(result_id),
        .result_data_o(result_data), .result_we_o(result_we),
        .flush_i(flush), .stat_accept_o(stat_acc), .stat_reject_o(stat_rej)
    );

    task automatic idle();
        issue_valid = 0; issue_instr = 0; issue_rs1 = 0; issue_rs2 = 0; issue_id = 0;
        cmd_ready = 0; done_valid = 0; done_id = 0; done_data = 0; done_we = 0;
        result_ready = 0; flush = 0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid: got %b expected 0", cmd_valid); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_result_valid: got %b expected 0", result_valid); end
        @(negedge clk);
        rst_n = 1;
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready: got %b expected 1", issue_ready); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid_rel: got %b expected 0", cmd_valid); end
        checks++; if ({result_id, result_data, result_we} !== '0) begin errors++; $display("FAIL reset_result_fields: got %h/%h/%b expected 0", result_id, result_data, result_we); end
        checks++; if ({stat_acc, stat_rej} !== 32'h0) begin errors++; $display("FAIL reset_stats: got %h/%h expected 0", stat_acc, stat_rej); end
        @(negedge clk);
    endtask

    task automatic test_accept();
        issue_valid = 1; issue_instr = 32'h0000100B; issue_rs1 = 5; issue_rs2 = 7; issue_id = 3;
        #1;
        checks++; if (issue_accept !== 1'b1) begin errors++; $display("FAIL accept_accept: got %b expected 1", issue_accept); end
        checks++; if (issue_wb !== 1'b1) begin errors++; $display("FAIL accept_writeback: got %b expected 1", issue_wb); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL accept_no_comb_path: got %b expected 0", cmd_valid); end
        @(negedge clk);
        issue_valid = 0;
        #1;
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL accept_cmd_valid: got %b expected 1", cmd_valid); end
        checks++; if (cmd_rs1 !== 5 || cmd_rs2 !== 7) begin errors++; $display("FAIL accept_cmd_rs: got %0d/%0d expected 5/7", cmd_rs1, cmd_rs2); end
        checks++; if (cmd_id !== 3 || cmd_we !== 1'b1) begin errors++; $display("FAIL accept_cmd_id_we: got %0d/%b expected 3/1", cmd_id, cmd_we); end
        checks++; if (cmd_instr !== 32'h0000100B) begin errors++; $display("FAIL accept_cmd_instr: got %h expected 0000100b", cmd_instr); end
        cmd_ready = 1;
        @(negedge clk);
        cmd_ready = 0;
        #1;
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL accept_pop: got %b expected 0", cmd_valid); end
    endtask

    task automatic test_reject();
        logic [15:0] exp_acc, exp_rej;
        issue_valid = 1; issue_instr = 32'h00000033; issue_id = 1;
        #1;
        checks++; if (issue_accept !== 1'b0 || issue_wb !== 1'b0) begin errors++; $display("FAIL reject_resp: got %b/%b expected 0/0", issue_accept, issue_wb); end
        @(negedge clk);
        issue_valid = 0;
        #1;
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reject_cmd_valid: got %b expected 0", cmd_valid); end
`ifdef MA_CVXIF_STATS_EN
        exp_acc = 16'd1; exp_rej = 16'd1;
`else
        exp_acc = 16'd0; exp_rej = 16'd0;
`endif
        checks++; if (stat_acc !== exp_acc || stat_rej !== exp_rej) begin errors++; $display("FAIL reject_stats: got %0d/%0d expected %0d/%0d", stat_acc, stat_rej, exp_acc, exp_rej); end
        @(negedge clk);
    endtask

    task automatic test_full_order();
        cmd_ready = 0;
        for (int i = 0; i < 4; i++) begin
            issue_valid = 1; issue_instr = 32'h0000000B | (32'(i) << 12);
            issue_id = IDW'(i); issue_rs1 = XLEN'(i * 16 + 1); issue_rs2 = XLEN'(i);
            #1;
            checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL full_ready_%0d: got %b expected 1", i, issue_ready); end
            @(negedge clk);
        end
        issue_id = 4'hF;
        #1;
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL full_ready_after4: got %b expected 0", issue_ready); end
        @(negedge clk);
        issue_valid = 0;
        cmd_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (cmd_valid !== 1'b1 || cmd_id !== IDW'(i)) begin errors++; $display("FAIL order_%0d: got valid=%b id=%0d expected valid=1 id=%0d", i, cmd_valid, cmd_id, i); end
            checks++; if (cmd_rs1 !== XLEN'(i * 16 + 1) || cmd_we !== i[0]) begin errors++; $display("FAIL order_data_%0d: got rs1=%0d we=%b expected rs1=%0d we=%b", i, cmd_rs1, cmd_we, i * 16 + 1, i[0]); end
            @(negedge clk);
        end
        cmd_ready = 0;
        #1;
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL full_drained: got %b expected 0", cmd_valid); end
        @(negedge clk);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            issue_valid = 1; issue_instr = 32'h0000000B; issue_id = IDW'(i + 8);
            @(negedge clk);
        end
        flush = 1; issue_instr = 32'h0000100B; issue_id = 4'hC;
        #1;
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", issue_ready); end
        @(negedge clk);
        flush = 0; issue_valid = 0;
        #1;
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL flush_cmd_valid: got %b expected 0", cmd_valid); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_after: got %b expected 1", issue_ready); end
        @(negedge clk);
        #1;
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped: got %b expected 0", cmd_valid); end
        @(negedge clk);
    endtask

    task automatic test_result_hold();
        done_valid = 1; done_id = 2; done_data = 32'hDEAD; done_we = 1; result_ready = 0;
        #1;
        checks++; if (done_ready !== 1'b1) begin errors++; $display("FAIL hold_done_ready_empty: got %b expected 1", done_ready); end
        @(negedge clk);
        done_id = 5; done_data = 32'hBEEF; done_we = 0;
        for (int i = 0; i < 3; i++) begin
            flush = (i == 1);
            #1;
            checks++; if (result_valid !== 1'b1 || result_id !== 2 || result_data !== 32'hDEAD || result_we !== 1'b1) begin errors++; $display("FAIL hold_stable_%0d: got %b/%0d/%h/%b expected 1/2/dead/1", i, result_valid, result_id, result_data, result_we); end
            checks++; if (done_ready !== 1'b0) begin errors++; $display("FAIL hold_done_ready_%0d: got %b expected 0", i, done_ready); end
            @(negedge clk);
        end
        flush = 0; done_valid = 0; result_ready = 1;
        #1;
        checks++; if (done_ready !== 1'b1) begin errors++; $display("FAIL hold_done_ready_rel: got %b expected 1", done_ready); end
        @(negedge clk);
        result_ready = 0;
        #1;
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL hold_cleared: got %b expected 0", result_valid); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        cmd_ready = 0;
        for (int i = 0; i < 2; i++) begin
            issue_valid = 1; issue_instr = 32'h0000100B; issue_id = IDW'(i);
            done_valid = (i == 0); done_id = 7; done_data = 32'h1234; done_we = 1;
            @(negedge clk);
        end
        idle();
        #2;
        rst_n = 0;
        #1;
        checks++; if (cmd_valid !== 1'b0 || result_valid !== 1'b0) begin errors++; $display("FAIL async_valids: got %b/%b expected 0/0", cmd_valid, result_valid); end
        checks++; if (result_data !== '0 || result_id !== '0) begin errors++; $display("FAIL async_result_fields: got %h/%h expected 0", result_data, result_id); end
        checks++; if ({stat_acc, stat_rej} !== 32'h0) begin errors++; $display("FAIL async_stats: got %h/%h expected 0", stat_acc, stat_rej); end
        @(negedge clk);
        rst_n = 1;
        #1;
        checks++; if (issue_ready !== 1'b1 || cmd_valid !== 1'b0) begin errors++; $display("FAIL async_release: got ready=%b cmd_valid=%b expected 1/0", issue_ready, cmd_valid); end
        @(negedge clk);
    endtask

    task automatic test_random();
        ent_t        q[$];
        ent_t        e;
        logic        res_v = 0;
        logic [IDW-1:0]  res_id = 0;
        logic [XLEN-1:0] res_data = 0;
        logic        res_we = 0;
        logic [15:0] exp_acc = 0, exp_rej = 0;
        logic [31:0] r;
        logic        exp_ready, acc, hs, exp_dready;
        for (int n = 0; n < 600; n++) begin
            r = $urandom;
            if ($urandom_range(1, 0) == 1) r[6:0] = 7'h0B;
            issue_valid = ($urandom_range(9, 0) < 7); issue_instr = r;
            issue_rs1 = $urandom; issue_rs2 = $urandom; issue_id = IDW'($urandom);
            cmd_ready = ($urandom_range(1, 0) == 1);
            done_valid = ($urandom_range(1, 0) == 1); done_id = IDW'($urandom);
            done_data = $urandom; done_we = ($urandom_range(1, 0) == 1);
            result_ready = ($urandom_range(1, 0) == 1);
            flush = ($urandom_range(15, 0) == 0);
            #1;
            acc = (r[6:0] == 7'h0B);
            exp_ready = (q.size() < DEPTH) && !flush;
            exp_dready = !res_v || result_ready;
            checks++; if (issue_ready !== exp_ready) begin errors++; $display("FAIL rnd_issue_ready @%0d: got %b expected %b", n, issue_ready, exp_ready); end
            checks++; if (issue_accept !== acc || issue_wb !== (acc && r[12])) begin errors++; $display("FAIL rnd_resp @%0d: got %b/%b expected %b/%b", n, issue_accept, issue_wb, acc, acc && r[12]); end
            checks++; if (cmd_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_cmd_valid @%0d: got %b expected %b", n, cmd_valid, q.size() != 0); end
            if (q.size() != 0) begin
                checks++;
                if (cmd_instr !== q[0].instr || cmd_rs1 !== q[0].rs1 || cmd_rs2 !== q[0].rs2 || cmd_id !== q[0].id || cmd_we !== q[0].we) begin
                    errors++; $display("FAIL rnd_cmd_head @%0d: got %h/%h/%h/%h/%b expected %h/%h/%h/%h/%b", n, cmd_instr, cmd_rs1, cmd_rs2, cmd_id, cmd_we, q[0].instr, q[0].rs1, q[0].rs2, q[0].id, q[0].we);
                end
            end
            checks++; if (done_ready !== exp_dready) begin errors++; $display("FAIL rnd_done_ready @%0d: got %b expected %b", n, done_ready, exp_dready); end
            checks++; if (result_valid !== res_v) begin errors++; $display("FAIL rnd_result_valid @%0d: got %b expected %b", n, result_valid, res_v); end
            if (res_v) begin
                checks++; if (result_id !== res_id || result_data !== res_data || result_we !== res_we) begin errors++; $display("FAIL rnd_result_fields @%0d: got %h/%h/%b expected %h/%h/%b", n, result_id, result_data, result_we, res_id, res_data, res_we); end
            end
            checks++; if (stat_acc !== exp_acc || stat_rej !== exp_rej) begin errors++; $display("FAIL rnd_stats @%0d: got %0d/%0d expected %0d/%0d", n, stat_acc, stat_rej, exp_acc, exp_rej); end

            hs = issue_valid && exp_ready;
            if (flush) q.delete();
            else begin
                if (q.size() != 0 && cmd_ready) void'(q.pop_front());
                if (hs && acc) begin
                    e.instr = r; e.rs1 = issue_rs1; e.rs2 = issue_rs2; e.id = issue_id; e.we = r[12];
                    q.push_back(e);
                end
            end
            if (done_valid && exp_dready) begin
                res_v = 1; res_id = done_id; res_data = done_data; res_we = done_we;
            end else if (result_ready) res_v = 0;
`ifdef MA_CVXIF_STATS_EN
            if (hs && acc && exp_acc != 16'hFFFF) exp_acc = exp_acc + 16'd1;
            if (hs && !acc && exp_rej != 16'hFFFF) exp_rej = exp_rej + 16'd1;
`endif
            @(negedge clk);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_accept();
        test_reject();
        test_full_order();
        test_flush();
        test_result_hold();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
